// File: rtl/load_store_unit.sv
// Load/store unit: one request in flight, big-endian byte/half/word access to a data memory.
// Latency: accept at edge N, memory access in cycle N+1, response from N+2 (faults respond from N+1).
// Backpressure: req_ready only in IDLE; response held stable until rsp_valid && rsp_ready.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   req_valid/req_ready + req_*      request channel (write, size, signed, addr, right-aligned wdata)
//   rsp_valid/rsp_ready + rsp_*      response channel (extended load data, fault flag)
//   mem_addr/hsize/w_en/wdata/rdata  data memory port (combinational read, write on clock edge)
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_hsize,
    output logic        mem_w_en,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [2:0]  req_bytes;
    logic [32:0] req_end;
    logic        req_fault;
    logic [31:0] load_ext;
    logic        in_access;

    // Fault check on the incoming request. The end address is formed in 33 bits
    // so an access that wraps past 0xFFFFFFFF is still seen as out of range.
    always_comb begin
        case (req_size)
            2'b00:   req_bytes = 3'd1;
            2'b01:   req_bytes = 3'd2;
            2'b10:   req_bytes = 3'd4;
            default: req_bytes = 3'd0;
        endcase
        req_end   = {1'b0, req_addr} + {30'b0, req_bytes};
        req_fault = (req_size == 2'b11)
                 || ((req_size == 2'b01) && req_addr[0])
                 || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                 || (req_end > 33'(MEM_BYTES));
    end

    // Memory returns the accessed value right-aligned; only extension is needed here.
    always_comb begin
        case (size_q)
            2'b00:   load_ext = signed_q ? {{24{mem_rdata[7]}}, mem_rdata[7:0]}
                                         : {24'b0, mem_rdata[7:0]};
            2'b01:   load_ext = signed_q ? {{16{mem_rdata[15]}}, mem_rdata[15:0]}
                                         : {16'b0, mem_rdata[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        size_d      = size_q;
        signed_d    = signed_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d     = req_write;
                    size_d      = req_size;
                    signed_d    = req_signed;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    rsp_rdata_d = 32'b0;
                    rsp_err_d   = req_fault;
                    // Faulted requests skip the memory cycle entirely.
                    state_d     = req_fault ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (!write_q) begin
                    rsp_rdata_d = load_ext;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            size_q      <= 2'b0;
            signed_q    <= 1'b0;
            addr_q      <= 32'b0;
            wdata_q     <= 32'b0;
            rsp_rdata_q <= 32'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign in_access = (state_q == ACCESS);
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Memory port is quiet outside ACCESS. rst_n gates the write enable directly
    // so a reset arriving mid-store suppresses the write on that very edge.
    assign mem_addr  = in_access ? addr_q : 32'b0;
    assign mem_hsize = in_access ? {1'b0, size_q} : 3'b0;
    assign mem_wdata = in_access ? wdata_q : 32'b0;
    assign mem_w_en  = in_access && write_q && rst_n;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, giving the number of addressable data-memory bytes.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1: the core presents a load/store request.
REQ-005 SHALL have port req_ready, output, 1: the unit accepts the request this cycle.
REQ-006 SHALL have port req_write, input, 1: 1 selects a store, 0 selects a load.
REQ-007 SHALL have port req_size, input, 2: 00 is byte, 01 is halfword, 10 is word, 11 is reserved.
REQ-008 SHALL have port req_signed, input, 1: 1 selects sign-extension of load data, 0 selects zero-extension.
REQ-009 SHALL have port req_addr, input, 32: the byte address.
REQ-010 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-011 SHALL have port rsp_valid, output, 1: a response is available.
REQ-012 SHALL have port rsp_ready, input, 1: the core consumes the response.
REQ-013 SHALL have port rsp_rdata, output, 32: the extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err, output, 1: the request was faulted.
REQ-015 SHALL have ports mem_addr (output, 32), mem_hsize (output, 3), mem_w_en (output, 1), mem_wdata (output, 32) and mem_rdata (input, 32), connecting to the data memory.
- The memory read is combinational.
- The memory write occurs on the clock edge.
- Multi-byte values are big-endian: the byte at addr is most significant, right-aligned in bits [8n-1:0].

Function
REQ-016 SHALL implement the states IDLE, ACCESS and RESP.
REQ-017 SHALL assert req_ready only in IDLE; acceptance is req_valid && req_ready.
REQ-018 SHALL, on acceptance, register write, size, signed, addr and wdata.
REQ-019 SHALL, on acceptance, compute the fault condition: reserved size, or halfword with addr[0]=1, or word with addr[1:0]!=0, or addr+bytes > MEM_BYTES.
- The address-plus-bytes comparison SHALL use 33-bit arithmetic so that wrap-around counts as a fault.
REQ-020 SHALL go IDLE to ACCESS for a non-faulted request, and IDLE to RESP for a faulted request, with no memory activity for the faulted request.
REQ-021 SHALL, in ACCESS, drive mem_addr=addr, mem_hsize={1'b0,size} and mem_wdata=wdata.
- mem_w_en SHALL be 1 only in ACCESS, only for a store, and only while rst_n=1.
REQ-022 SHALL, in ACCESS for a load, capture the extended mem_rdata into rsp_rdata.
- Byte uses [7:0], halfword uses [15:0], word uses [31:0].
- Sign- or zero-extension follows the registered signed bit.
REQ-023 SHALL go ACCESS to RESP unconditionally, after exactly one cycle.
REQ-024 SHALL hold rsp_valid=1 in RESP, with rsp_rdata and rsp_err stable until rsp_valid && rsp_ready.
REQ-025 SHALL go RESP to IDLE on rsp_ready; req_ready returns the following cycle.
REQ-026 SHALL meet this latency: accepted at edge N, ACCESS in cycle N+1, rsp_valid from cycle N+2; a faulted request gives rsp_valid from cycle N+1.
REQ-027 SHALL, outside ACCESS, drive mem_addr=0, mem_hsize=0, mem_wdata=0 and mem_w_en=0.
REQ-028 SHALL drive rsp_rdata=0 for stores and for faulted requests.
REQ-029 SHALL hold one request at most in flight; req_valid during ACCESS or RESP is ignored and not accepted.
REQ-030 SHALL keep rsp_valid at 0 in IDLE, and SHALL ignore rsp_ready outside RESP.

Reset
REQ-031 SHALL, when rst_n=0 at a clock edge, set the state to IDLE, and set rsp_valid, rsp_err and rsp_rdata to 0 and all registered request fields to 0.
REQ-032 SHALL, if rst_n=0 while in ACCESS with a store, force mem_w_en=0 combinationally so that no memory write occurs on that edge.
REQ-033 SHALL, if reset is asserted in RESP, discard the pending response; rsp_valid=0 after the edge.
REQ-034 SHALL drive req_ready=1 in the first cycle after rst_n returns to 1.

Verification
REQ-035 SHALL verify a word store followed by a word load:
- Store at 0x10, data 0xDEADBEEF, produces mem_w_en=1 for exactly one cycle, then rsp_valid=1 with rsp_err=0.
- Load at 0x10 then returns rsp_rdata=0xDEADBEEF.
REQ-036 SHALL verify byte extension:
- Store byte 0x80 at 0x21.
- Signed byte load returns 0xFFFFFF80.
- Unsigned byte load returns 0x00000080.
REQ-037 SHALL verify halfword extension:
- Store 0x8001 at 0x30.
- Signed halfword load returns 0xFFFF8001; memory byte 0x30 holds 0x80 and byte 0x31 holds 0x01.
REQ-038 SHALL verify faults:
- Halfword at 0x31, word at 0x3FE, and word at 0xFFFFFFFC each give rsp_err=1 one cycle after acceptance, with rsp_rdata=0.
- mem_w_en stays 0 throughout.
REQ-039 SHALL verify backpressure: holding rsp_ready=0 for 5 cycles keeps rsp_valid, rsp_rdata and rsp_err stable and req_ready=0; raising rsp_ready returns the unit to IDLE the next cycle.
REQ-040 SHALL verify reset during a store: rst_n=0 in the ACCESS cycle of a store of 0x12345678 to 0x40 leaves memory unchanged, and gives rsp_valid=0 and req_ready=1 after reset is released.
